arrow_scroller: RTL
===================

Name: arrow_scroller

Overview:
- Upstream feeder for the VGA arrow renderer: owns the position of every on-screen scrolling arrow (lane + Y) in a small slot pool.
- Accepts spawn requests from the song/pattern sequencer and advances arrows upward by STEP every TICK_DIV clocks.
- Resolves player hit attempts against the target line and retires arrows that scroll past it.
- Publishes a frame-stable (vsync-latched) snapshot of the slot pool that the renderer compares against oCurrent_X/oCurrent_Y.

Parameters:
- NUM_SLOTS, 4, number of concurrent arrows (1..8)
- Y_W, 11, Y coordinate width (matches VGA_Ctrl oCurrent_Y)
- TICK_DIV, 1250000, clocks per scroll step (40 Hz at 50 MHz)
- STEP, 1, pixels moved per tick
- SPAWN_Y, 480, initial Y of a new arrow
- TARGET_Y, 165, Y of the target line
- WINDOW, 12, hit tolerance in pixels, inclusive
- MISS_Y, 100, arrow retired as a miss when Y <= MISS_Y at a tick; must be >= STEP

Ports:
- iCLK  in  1  system clock
- iRST_N  in  1  asynchronous active-low reset
- iVS  in  1  active-low vertical sync from VGA_Ctrl (oVGA_VS), same clock domain
- iSpawn_Valid  in  1  spawn request
- iSpawn_Lane  in  2  0=left 1=down 2=up 3=right
- oSpawn_Ready  out  1  a free slot exists
- iHit_Valid  in  1  single-cycle player press
- iHit_Lane  in  2  lane pressed
- oHit  out  1  one-cycle pulse: press matched an arrow
- oBad  out  1  one-cycle pulse: press matched nothing
- oMiss  out  1  one-cycle pulse: at least one arrow retired past MISS_Y this tick
- oHit_Count  out  16  saturating count of hits
- oSlot_Active  out  NUM_SLOTS  snapshot active flags
- oSlot_Lane  out  2*NUM_SLOTS  snapshot lanes, slot i at [2i+1:2i]
- oSlot_Y  out  Y_W*NUM_SLOTS  snapshot Y, slot i at [Y_W*i+Y_W-1:Y_W*i]

Behaviour:
- Reset (async assert, sync release): all slots inactive, Y=0, lane=0; prescaler=0; all pulses 0; oHit_Count=0; snapshot all 0. oSpawn_Ready=1 one cycle after release.
- Prescaler: counts 0..TICK_DIV-1; tick is a one-cycle internal strobe when the count wraps.
- Live slot state per slot: active, lane, y. Each cycle, in priority order, evaluated on registered (pre-update) state:
  1. Hit: if iHit_Valid, select the lowest-index active slot with lane==iHit_Lane and |y-TARGET_Y|<=WINDOW.
     - Match: clear that slot, oHit=1 next cycle, oHit_Count+1 (saturate at 16'hFFFF).
     - No match: oBad=1 next cycle.
  2. Tick: for every active slot not consumed by step 1:
     - y<=MISS_Y: clear the slot, assert oMiss.
     - Otherwise: y<=y-STEP. Unsigned arithmetic; wrap is impossible because MISS_Y>=STEP.
  3. Spawn: iSpawn_Valid && oSpawn_Ready writes the lowest-index slot that is free in registered state; y=SPAWN_Y, lane=iSpawn_Lane. The new arrow is not decremented in its spawn cycle.
- oSpawn_Ready = OR of ~active over registered state. A slot freed this cycle is not reusable until the next cycle.
- iSpawn_Valid while oSpawn_Ready=0: request ignored, no state change. The sequencer holds valid until accepted.
- Snapshot: iVS is registered once. On the detected falling edge (start of vsync), copy all live slot state to oSlot_* in one cycle. Outputs are stable for the whole visible frame.
- Pulses oHit/oBad/oMiss are registered and high for exactly one cycle per event; a hit and a miss in the same cycle both assert.
- Reset mid-operation: all state clears immediately; snapshot clears without waiting for vsync.

Decomposition:
- Shared package dcr_pkg:
  - lane encodings LANE_LEFT/DOWN/UP/RIGHT
  - Y_W
  - default TARGET_Y / SPAWN_Y geometry constants, shared with the renderer
- Sub-module arrow_tick_prescaler: parameter TICK_DIV; ports iCLK, iRST_N, oTick.
- Slot update and priority selection stay in arrow_scroller.

Test Plan (TICK_DIV=4, STEP=5, SPAWN_Y=200, TARGET_Y=165, WINDOW=12, MISS_Y=100, NUM_SLOTS=4):
- Reset then spawn lane 2 -> slot0 active, y=200; after 4 ticks live y=180; snapshot stays 0 until an iVS falling edge, then oSlot_Y[0]=180 and oSlot_Lane[1:0]=2.
- Spawn 4 arrows back-to-back -> slots 0..3 filled, oSpawn_Ready=0; a 5th held valid is not accepted until one slot retires, then it lands in that slot index.
- Arrow lane 1 at y=175 (in window), iHit_Valid lane 1 -> oHit pulse 1 cycle, slot cleared, oHit_Count=1; repeat press -> oBad pulse, count unchanged.
- Press lane 0 when only lane 3 arrows exist, or lane 0 at y=180 (outside window) -> oBad only.
- Arrow reaches y=100 -> next tick clears it and pulses oMiss; with two arrows both at 100, a single oMiss pulse and both cleared.
- Hit and tick in the same cycle on an arrow at y=160 -> slot cleared by hit; other slots decrement; no oMiss. Async reset asserted mid-scroll -> all outputs 0 immediately.

Source files
------------

// File: rtl/dcr_pkg.sv
// Shared definitions for the dance-arrow pipeline: lane codes, screen
// geometry defaults and the hit-window test used by the scroller.
package dcr_pkg;

    // Lane codes used by the sequencer, the scroller and the renderer.
    typedef enum logic [1:0] {
        LANE_LEFT  = 2'd0,
        LANE_DOWN  = 2'd1,
        LANE_UP    = 2'd2,
        LANE_RIGHT = 2'd3
    } lane_e;

    // Y coordinate width, same as the VGA controller's oCurrent_Y.
    localparam int DCR_Y_W      = 11;

    // Default geometry, shared with the renderer so the target line it
    // draws is the one the scroller judges against.
    localparam int DCR_TARGET_Y = 165;
    localparam int DCR_SPAWN_Y  = 480;

    // True when y lies within +/-window of target, inclusive. The test is
    // written without subtraction so small targets cannot underflow.
    function automatic logic in_window(input int y, input int target, input int window);
        return ((y + window) >= target) && (y <= (target + window));
    endfunction

endpackage

// File: rtl/arrow_tick_prescaler.sv
// Free-running divider that produces the scroll tick: a one-cycle strobe
// on the cycle where the count sits at TICK_DIV-1 and is about to wrap.
module arrow_tick_prescaler #(
    parameter int TICK_DIV = 1250000
) (
    input  logic iCLK,
    input  logic iRST_N,
    output logic oTick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] cnt_q;

    assign oTick = (cnt_q == CW'(TICK_DIV - 1));

    // Count 0..TICK_DIV-1 and wrap on the tick.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            cnt_q <= '0;
        end else if (oTick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/arrow_scroller.sv
// Owns the pool of on-screen arrows: accepts spawns, scrolls them upward on
// each tick, judges player presses against the target line, retires arrows
// that pass the miss line, and publishes a vsync-latched copy of the pool.
//
// Spawn handshake: a spawn is accepted on a clock edge where iSpawn_Valid
// and oSpawn_Ready are both high; with oSpawn_Ready low the request is
// ignored and the sequencer keeps iSpawn_Valid (and the lane) held.
module arrow_scroller
    import dcr_pkg::*;
#(
    parameter int NUM_SLOTS = 4,
    parameter int Y_W       = DCR_Y_W,
    parameter int TICK_DIV  = 1250000,
    parameter int STEP      = 1,
    parameter int SPAWN_Y   = DCR_SPAWN_Y,
    parameter int TARGET_Y  = DCR_TARGET_Y,
    parameter int WINDOW    = 12,
    parameter int MISS_Y    = 100
) (
    input  logic                     iCLK,
    input  logic                     iRST_N,
    input  logic                     iVS,
    input  logic                     iSpawn_Valid,
    input  logic [1:0]               iSpawn_Lane,
    output logic                     oSpawn_Ready,
    input  logic                     iHit_Valid,
    input  logic [1:0]               iHit_Lane,
    output logic                     oHit,
    output logic                     oBad,
    output logic                     oMiss,
    output logic [15:0]              oHit_Count,
    output logic [NUM_SLOTS-1:0]     oSlot_Active,
    output logic [2*NUM_SLOTS-1:0]   oSlot_Lane,
    output logic [Y_W*NUM_SLOTS-1:0] oSlot_Y
);

    logic                 tick;
    logic                 ready_en_q;
    logic                 vs_q;
    logic                 vs_fall;

    logic [NUM_SLOTS-1:0] active_q;
    lane_e                lane_q   [NUM_SLOTS];
    logic [Y_W-1:0]       y_q      [NUM_SLOTS];

    logic [NUM_SLOTS-1:0] nxt_active;
    lane_e                nxt_lane [NUM_SLOTS];
    logic [Y_W-1:0]       nxt_y    [NUM_SLOTS];

    logic [NUM_SLOTS-1:0] hit_sel;
    logic                 hit_found;
    logic [NUM_SLOTS-1:0] spawn_sel;
    logic                 spawn_found;
    logic                 miss_any;

    arrow_tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .iCLK   (iCLK),
        .iRST_N (iRST_N),
        .oTick  (tick)
    );

    // Ready only once out of reset, and only while some slot is free in
    // registered state; a slot freed this cycle becomes usable next cycle.
    assign oSpawn_Ready = ready_en_q && (|(~active_q));
    assign vs_fall      = vs_q && !iVS;

    // Pick the lowest-index slot for a hit and for a spawn.
    always_comb begin
        hit_sel     = '0;
        hit_found   = 1'b0;
        spawn_sel   = '0;
        spawn_found = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (iHit_Valid && !hit_found && active_q[i] &&
                (lane_q[i] == lane_e'(iHit_Lane)) &&
                in_window(int'(y_q[i]), TARGET_Y, WINDOW)) begin
                hit_sel[i] = 1'b1;
                hit_found  = 1'b1;
            end
            if (iSpawn_Valid && oSpawn_Ready && !spawn_found && !active_q[i]) begin
                spawn_sel[i] = 1'b1;
                spawn_found  = 1'b1;
            end
        end
    end

    // Next slot state: hit clears first, tick scrolls or retires the rest,
    // spawn fills a slot that was free (so never one touched above).
    always_comb begin
        nxt_active = active_q;
        nxt_lane   = lane_q;
        nxt_y      = y_q;
        miss_any   = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (hit_sel[i]) begin
                nxt_active[i] = 1'b0;
            end else if (tick && active_q[i]) begin
                if (y_q[i] <= Y_W'(MISS_Y)) begin
                    nxt_active[i] = 1'b0;
                    miss_any      = 1'b1;
                end else begin
                    nxt_y[i] = y_q[i] - Y_W'(STEP);
                end
            end
            if (spawn_sel[i]) begin
                nxt_active[i] = 1'b1;
                nxt_lane[i]   = lane_e'(iSpawn_Lane);
                nxt_y[i]      = Y_W'(SPAWN_Y);
            end
        end
    end

    // Live slot state register.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            active_q <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                lane_q[i] <= LANE_LEFT;
                y_q[i]    <= '0;
            end
        end else begin
            active_q <= nxt_active;
            lane_q   <= nxt_lane;
            y_q      <= nxt_y;
        end
    end

    // Event pulses, hit counter and the post-reset ready enable.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            ready_en_q <= 1'b0;
            oHit       <= 1'b0;
            oBad       <= 1'b0;
            oMiss      <= 1'b0;
            oHit_Count <= '0;
        end else begin
            ready_en_q <= 1'b1;
            oHit       <= hit_found;
            oBad       <= iHit_Valid && !hit_found;
            oMiss      <= miss_any;
            if (hit_found && (oHit_Count != 16'hFFFF)) begin
                oHit_Count <= oHit_Count + 16'd1;
            end
        end
    end

    // Register vsync and latch the live pool at the start of vsync.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            vs_q         <= 1'b1;
            oSlot_Active <= '0;
            oSlot_Lane   <= '0;
            oSlot_Y      <= '0;
        end else begin
            vs_q <= iVS;
            if (vs_fall) begin
                oSlot_Active <= active_q;
                for (int i = 0; i < NUM_SLOTS; i++) begin
                    oSlot_Lane[2*i +: 2]   <= lane_q[i];
                    oSlot_Y[Y_W*i +: Y_W] <= y_q[i];
                end
            end
        end
    end

endmodule
